// File: rtl/ksa_pipe.sv
// ksa_pipe: pipelined, valid/ready flow-controlled Kogge-Stone adder.
//   {c_out,s} = a + b + c_in, D = $clog2(WIDTH)+2 register stages.
//   Optional macro KSA_PIPE_CHECK_EN carries a reference sum down the pipe
//   and raises a sticky err on any output transfer that disagrees with it.
module ksa_pipe #(
   parameter int WIDTH  = 16,
   parameter int LEVELS = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             err
);
   localparam int D = LEVELS + 2;

   // Stage k valid bits; stage D-1 is the output register.
   logic [D-1:0]     vld_pipe_q;
   logic [D:0]       rdy;

   // Prefix state per stage: group generate/propagate, raw half-sum, carry-in.
   logic [WIDTH-1:0] g_q  [0:LEVELS];
   logic [WIDTH-1:0] p_q  [0:LEVELS-1];
   logic [WIDTH-1:0] hp_q [0:LEVELS];
   logic [LEVELS:0]  ci_q;
   logic [WIDTH-1:0] g_d  [1:LEVELS];
   logic [WIDTH-1:0] p_d  [1:LEVELS-1];
   logic [WIDTH-1:0] s_q, s_d;
   logic             co_q, co_d;

   // Bubble-collapsing ready chain: a stage can load if empty or its successor moves.
   assign rdy[D] = out_ready;
   for (genvar k = 0; k < D; k++) begin : g_rdy
      assign rdy[k] = !vld_pipe_q[k] | rdy[k+1];
   end
   assign in_ready = rdy[0];

   // Prefix levels; level 1 folds c_in into bit 0 as a generate at position -1.
   for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int SPAN = 1 << (k - 1);
      logic [WIDTH-1:0] g_in;
      if (k == 1) begin : g_fold
         assign g_in = {g_q[0][WIDTH-1:1], g_q[0][0] | (p_q[0][0] & ci_q[0])};
      end else begin : g_nofold
         assign g_in = g_q[k-1];
      end
      // Group generate combine for this level.
      always_comb begin
         g_d[k] = g_in;
         for (int i = SPAN; i < WIDTH; i++)
            g_d[k][i] = g_in[i] | (p_q[k-1][i] & g_in[i-SPAN]);
      end
      if (k < LEVELS) begin : g_pp
         // Group propagate combine; the last level has no consumer for it.
         always_comb begin
            p_d[k] = p_q[k-1];
            for (int i = SPAN; i < WIDTH; i++)
               p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-SPAN];
         end
      end
   end

   // Final sum: carry into bit i is the group generate of bit i-1 (c_in for bit 0).
   assign s_d  = hp_q[LEVELS] ^ {g_q[LEVELS][WIDTH-2:0], ci_q[LEVELS]};
   assign co_d = g_q[LEVELS][WIDTH-1];

   // Pipeline advance: each stage loads from its predecessor when ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         ci_q       <= '0;
         s_q        <= '0;
         co_q       <= 1'b0;
         for (int k = 0; k <= LEVELS; k++) begin
            g_q[k]  <= '0;
            hp_q[k] <= '0;
         end
         for (int k = 0; k < LEVELS; k++) p_q[k] <= '0;
      end else begin
         if (rdy[0]) begin
            vld_pipe_q[0] <= in_valid;
            if (in_valid) begin
               g_q[0]  <= a & b;
               p_q[0]  <= a ^ b;
               hp_q[0] <= a ^ b;
               ci_q[0] <= c_in;
            end
         end
         for (int k = 1; k <= LEVELS; k++) begin
            if (rdy[k]) begin
               vld_pipe_q[k] <= vld_pipe_q[k-1];
               g_q[k]        <= g_d[k];
               hp_q[k]       <= hp_q[k-1];
               ci_q[k]       <= ci_q[k-1];
               if (k < LEVELS) p_q[k] <= p_d[k];
            end
         end
         if (rdy[D-1]) begin
            vld_pipe_q[D-1] <= vld_pipe_q[D-2];
            if (vld_pipe_q[D-2]) begin
               s_q  <= s_d;
               co_q <= co_d;
            end
         end
      end
   end

   assign out_valid = vld_pipe_q[D-1];
   assign s         = s_q;
   assign c_out     = co_q;

`ifdef KSA_PIPE_CHECK_EN
   logic [WIDTH:0] ref_q [0:D-1];
   logic           err_q;

   // Reference sum travels with its operands; mismatch on output transfer is sticky.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
         for (int k = 0; k < D; k++) ref_q[k] <= '0;
      end else begin
         if (rdy[0] && in_valid)
            ref_q[0] <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
         for (int k = 1; k < D; k++)
            if (rdy[k] && vld_pipe_q[k-1]) ref_q[k] <= ref_q[k-1];
         if (out_valid && out_ready && ({co_q, s_q} != ref_q[D-1]))
            err_q <= 1'b1;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ksa_pipe.sv
// tb_ksa_pipe: randomized and directed checks of ksa_pipe against a queue-based
// model that computes a+b+c_in with plain arithmetic and tracks acceptance order.
module tb_ksa_pipe;
   localparam int W = 16;
   localparam int D = $clog2(W) + 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         c_in = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] s;
   logic         c_out;
   logic         err;

   ksa_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .c_out(c_out), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W:0] sum;
      int         cyc;
   } exp_t;

   exp_t       q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   bit         lat_on  = 1'b0;
   bit         hold_pend = 1'b0;
   logic [W:0] hold_val;
   logic       last_in_ready;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive at negedge, sample mid-cycle, score transfers.
   task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic ordy, output logic acc);
      exp_t e;
      @(negedge clk);
      in_valid  = iv;
      a         = iv ? ia : W'($urandom);
      b         = iv ? ib : W'($urandom);
      c_in      = iv ? ic : 1'($urandom);
      out_ready = ordy;
      #1;
      if (hold_pend) begin
         check("hold_valid", out_valid, 1);
         check("hold_data", {c_out, s}, hold_val);
      end
      if (out_valid) begin
         check("spurious", q.size() != 0, 1);
         if (out_ready && q.size() != 0) begin
            e = q.pop_front();
            check("sum", {c_out, s}, e.sum);
            check("err", err, 0);
            if (lat_on) check("latency", cyc - e.cyc, D);
         end
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {c_out, s};
      last_in_ready = in_ready;
      acc = iv && in_ready;
      if (acc) begin
         e.sum = {1'b0, ia} + {1'b0, ib} + (W+1)'(ic);
         e.cyc = cyc;
         q.push_back(e);
      end
      cyc++;
   endtask

   task automatic drain();
      logic acc;
      for (int i = 0; i < 40 && q.size() != 0; i++) step(0, 0, 0, 0, 1, acc);
      check("drain_left", q.size(), 0);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_s", s, 0);
      check("rst_c_out", c_out, 0);
      check("rst_err", err, 0);
      q.delete();
      hold_pend = 1'b0;
      in_valid  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("rst_in_ready", in_ready, 1);
   endtask

   initial begin
      logic acc;
      int   idx;
      logic [W-1:0] va [10];
      logic [W-1:0] vb [10];
      logic         vc [10];

      do_reset();

      // Carry ripple across all bits, latency checked on each result.
      lat_on = 1'b1;
      step(1, 16'hFFFF, 16'h0001, 0, 1, acc);
      drain();
      step(1, 16'hFFFF, 16'h0000, 1, 1, acc);
      drain();

      // Streaming sweep: one per cycle, no gaps (latency stays exactly D).
      idx = 0;
      for (int i = 0; i < 1024; i++) begin
         step(1, W'(i), W'((i * 37 + 5) & 1023), 1'(i), 1, acc);
         idx += int'(acc);
      end
      check("sweep_accepts", idx, 1024);
      drain();
      lat_on = 1'b0;

      // Backpressure: 12 stalled cycles offering 10 sets.
      for (int i = 0; i < 10; i++) begin
         va[i] = W'($urandom);
         vb[i] = W'($urandom);
         vc[i] = 1'($urandom);
      end
      idx = 0;
      for (int i = 0; i < 12; i++) begin
         step(idx < 10, va[idx % 10], vb[idx % 10], vc[idx % 10], 0, acc);
         idx += int'(acc);
      end
      check("bp_accepted", idx, D);
      check("bp_in_ready", last_in_ready, 0);
      for (int i = 0; i < 40 && (idx < 10 || q.size() != 0); i++) begin
         step(idx < 10, va[idx % 10], vb[idx % 10], vc[idx % 10], 1, acc);
         idx += int'(acc);
      end
      check("bp_all_in", idx, 10);
      check("bp_all_out", q.size(), 0);

      // Random valid and ready, 10k cycles.
      for (int i = 0; i < 10000; i++)
         step(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), acc);
      drain();

      // Mid-stream reset with a full, stalled pipe.
      for (int i = 0; i < 8; i++)
         step(1, W'($urandom), W'($urandom), 1'($urandom), 0, acc);
      check("pre_rst_valid", out_valid, 1);
      do_reset();
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, acc);
      lat_on = 1'b1;
      step(1, 16'h1234, 16'hEDCC, 0, 1, acc);
      step(1, 16'h8000, 16'h8000, 1, 1, acc);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
